// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control bit positions,
// default widths and small helpers used across the stage registers.
package mips_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam int M_BRANCH_NE = 3;
  localparam int M_BRANCH    = 2;
  localparam int M_MEM_READ  = 1;
  localparam int M_MEM_WRITE = 0;

  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  function automatic logic branch_taken(
    input logic br,
    input logic br_ne,
    input logic zero
  );
    return br & (zero ^ br_ne);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset;
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (inc && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with stall/flush, valid-gated controls,
// registered branch decision, forwarding export and perf counters.
module ex_mem_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int WB_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [3:0]        m_in,
  input  logic              zero_flag_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] write_data_in,
  input  logic [REG_AW-1:0] write_back_reg_in,
  input  logic [DATA_W-1:0] pc_add_in,
  output logic              valid_out,
  output logic [WB_W-1:0]   wb_out,
  output logic              branch,
  output logic              mem_read,
  output logic              mem_write,
  output logic              zero_flag_out,
  output logic              pc_src,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_data_out,
  output logic [DATA_W-1:0] pc_add_out,
  output logic [REG_AW-1:0] write_back_reg_out,
  output logic              fwd_reg_write,
  output logic [REG_AW-1:0] fwd_reg_addr,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  bubble_count
);

  logic            valid_r;
  logic [WB_W-1:0] wb_r;
  logic [3:0]      m_r;
  logic            stall_inc;
  logic            bubble_inc;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r            <= 1'b0;
      wb_r               <= '0;
      m_r                <= '0;
      zero_flag_out      <= 1'b0;
      alu_result_out     <= '0;
      write_data_out     <= '0;
      pc_add_out         <= '0;
      write_back_reg_out <= '0;
    end else if (flush || !stall) begin
      // Data still loads on flush; it is don't-care once valid drops.
      valid_r            <= valid_in & ~flush;
      wb_r               <= flush ? '0 : wb_in;
      m_r                <= flush ? 4'b0 : m_in;
      zero_flag_out      <= zero_flag_in;
      alu_result_out     <= alu_result_in;
      write_data_out     <= write_data_in;
      pc_add_out         <= pc_add_in;
      write_back_reg_out <= write_back_reg_in;
    end
  end

  assign valid_out = valid_r;
  assign wb_out    = wb_r & {WB_W{valid_r}};
  assign branch    = m_r[M_BRANCH] & valid_r;
  assign mem_read  = m_r[M_MEM_READ] & valid_r;
  assign mem_write = m_r[M_MEM_WRITE] & valid_r;
  assign pc_src    = valid_r &
    branch_taken(m_r[M_BRANCH], m_r[M_BRANCH_NE], zero_flag_out);

  assign fwd_reg_write = wb_r[WB_REG_WRITE] & valid_r;
  assign fwd_reg_addr  = write_back_reg_out;

  assign stall_inc  = stall & ~flush;
  assign bubble_inc = flush | (~stall & ~valid_in);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (bubble_inc),
    .count (bubble_count)
  );

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench for ex_mem_stage_reg: default instance plus a
// 4-bit-counter instance sharing the same stimulus.
module tb_ex_mem_stage_reg;

  logic        clock = 1'b0;
  logic        reset, stall, flush, valid_in, zero_flag_in;
  logic [1:0]  wb_in;
  logic [3:0]  m_in;
  logic [31:0] alu_result_in, write_data_in, pc_add_in;
  logic [4:0]  write_back_reg_in;

  logic        valid_out, branch, mem_read, mem_write;
  logic        zero_flag_out, pc_src, fwd_reg_write;
  logic [1:0]  wb_out;
  logic [31:0] alu_result_out, write_data_out, pc_add_out;
  logic [4:0]  write_back_reg_out, fwd_reg_addr;
  logic [15:0] stall_count, bubble_count;

  logic        v4, br4, mr4, mw4, z4, ps4, fw4;
  logic [1:0]  wb4;
  logic [31:0] alu4, wd4, pc4;
  logic [4:0]  wr4, fa4;
  logic [3:0]  sc4, bc4;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ex_mem_stage_reg dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .wb_in(wb_in), .m_in(m_in),
    .zero_flag_in(zero_flag_in), .alu_result_in(alu_result_in),
    .write_data_in(write_data_in),
    .write_back_reg_in(write_back_reg_in), .pc_add_in(pc_add_in),
    .valid_out(valid_out), .wb_out(wb_out), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write),
    .zero_flag_out(zero_flag_out), .pc_src(pc_src),
    .alu_result_out(alu_result_out), .write_data_out(write_data_out),
    .pc_add_out(pc_add_out), .write_back_reg_out(write_back_reg_out),
    .fwd_reg_write(fwd_reg_write), .fwd_reg_addr(fwd_reg_addr),
    .stall_count(stall_count), .bubble_count(bubble_count)
  );

  ex_mem_stage_reg #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .wb_in(wb_in), .m_in(m_in),
    .zero_flag_in(zero_flag_in), .alu_result_in(alu_result_in),
    .write_data_in(write_data_in),
    .write_back_reg_in(write_back_reg_in), .pc_add_in(pc_add_in),
    .valid_out(v4), .wb_out(wb4), .branch(br4),
    .mem_read(mr4), .mem_write(mw4),
    .zero_flag_out(z4), .pc_src(ps4),
    .alu_result_out(alu4), .write_data_out(wd4),
    .pc_add_out(pc4), .write_back_reg_out(wr4),
    .fwd_reg_write(fw4), .fwd_reg_addr(fa4),
    .stall_count(sc4), .bubble_count(bc4)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1; stall = 1; flush = 1; valid_in = 1; zero_flag_in = 1;
    wb_in = 2'b11; m_in = 4'b1111;
    alu_result_in = '1; write_data_in = '1; pc_add_in = '1;
    write_back_reg_in = '1;
    step(); step();
    check("rst_valid", valid_out, 0);
    check("rst_pc_src", pc_src, 0);
    check("rst_wb", wb_out, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_stall_cnt", stall_count, 0);
    check("rst_bubble_cnt", bubble_count, 0);
    check("rst_alu", alu_result_out, 0);

    // plain load
    reset = 0; stall = 0; flush = 0;
    valid_in = 1; m_in = 4'b0010; wb_in = 2'b11; zero_flag_in = 0;
    alu_result_in = 32'h40; write_back_reg_in = 5'd9;
    write_data_in = 32'hDEAD_BEEF; pc_add_in = 32'h0;
    step();
    check("ld_valid", valid_out, 1);
    check("ld_mem_read", mem_read, 1);
    check("ld_mem_write", mem_write, 0);
    check("ld_alu", alu_result_out, 32'h40);
    check("ld_wdata", write_data_out, 32'hDEAD_BEEF);
    check("ld_fwd_we", fwd_reg_write, 1);
    check("ld_fwd_addr", fwd_reg_addr, 9);
    check("ld_wb", wb_out, 2'b11);
    check("ld_pc_src", pc_src, 0);

    // beq taken
    m_in = 4'b0100; zero_flag_in = 1; pc_add_in = 32'h100; wb_in = 2'b00;
    step();
    check("beq_pc_src", pc_src, 1);
    check("beq_pc_add", pc_add_out, 32'h100);
    check("beq_branch", branch, 1);
    check("beq_fwd_we", fwd_reg_write, 0);

    // bne taken / not taken
    m_in = 4'b1100; zero_flag_in = 0;
    step();
    check("bne_nz_pc_src", pc_src, 1);
    zero_flag_in = 1;
    step();
    check("bne_z_pc_src", pc_src, 0);

    // branch_ne alone has no effect
    m_in = 4'b1000; zero_flag_in = 0;
    step();
    check("bne_only_pc_src", pc_src, 0);

    // invalid load becomes a bubble
    valid_in = 0; m_in = 4'b0111; wb_in = 2'b11; zero_flag_in = 1;
    step();
    check("bub_valid", valid_out, 0);
    check("bub_mem_read", mem_read, 0);
    check("bub_mem_write", mem_write, 0);
    check("bub_branch", branch, 0);
    check("bub_wb", wb_out, 0);
    check("bub_fwd_we", fwd_reg_write, 0);
    check("bub_cnt", bubble_count, 1);

    // stall holds entry A
    valid_in = 1; m_in = 4'b0000; wb_in = 2'b10; zero_flag_in = 0;
    alu_result_in = 32'h11;
    step();
    check("a_alu", alu_result_out, 32'h11);
    check("a_stall_cnt", stall_count, 0);
    stall = 1; alu_result_in = 32'h22;
    step();
    check("stall1_alu", alu_result_out, 32'h11);
    step();
    check("stall2_alu", alu_result_out, 32'h11);
    step();
    check("stall3_alu", alu_result_out, 32'h11);
    check("stall3_valid", valid_out, 1);
    check("stall_cnt3", stall_count, 3);
    stall = 0;
    step();
    check("unstall_alu", alu_result_out, 32'h22);
    check("unstall_cnt", stall_count, 3);

    // flush while stalled
    stall = 1; flush = 1; valid_in = 1; m_in = 4'b0100;
    zero_flag_in = 1; wb_in = 2'b11; alu_result_in = 32'h33;
    step();
    check("fl_valid", valid_out, 0);
    check("fl_pc_src", pc_src, 0);
    check("fl_wb", wb_out, 0);
    check("fl_alu", alu_result_out, 32'h33);
    check("fl_bubble_cnt", bubble_count, 2);
    check("fl_stall_cnt", stall_count, 3);

    // recover with taken branch
    stall = 0; flush = 0;
    step();
    check("rec_pc_src", pc_src, 1);

    // reset mid-operation beats stall+flush
    reset = 1; stall = 1; flush = 1;
    step();
    check("mrst_valid", valid_out, 0);
    check("mrst_pc_src", pc_src, 0);
    check("mrst_stall_cnt", stall_count, 0);
    check("mrst_bubble_cnt", bubble_count, 0);

    // saturation on the 4-bit instance
    reset = 0; flush = 0; stall = 1;
    for (int i = 0; i < 20; i++) step();
    check("sat4_stall", sc4, 15);
    check("sat16_stall", stall_count, 20);
    step();
    check("sat4_hold", sc4, 15);
    check("sat16_more", stall_count, 21);
    check("sat4_bubble", bc4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
